// File: rtl/dda_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : dda_cmd_sequencer
//  Description : Host command parser, DDA register file, run control and
//                v1/v2 reply serialiser sitting between a byte UART and a DDA.
//  Revision    : 1.0  initial release
// ============================================================================
module dda_cmd_sequencer #(
    parameter int N         = 16,
    parameter int REG_BYTES = 10,
    parameter int TIMEOUT   = 65535
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rx_valid,
    input  logic [7:0]   rx_byte,
    input  logic         tx_busy,
    output logic         tx_start,
    output logic [7:0]   tx_byte,
    output logic         dda_load,
    output logic         dda_en,
    input  logic [N-1:0] v1,
    input  logic [N-1:0] v2,
    output logic [N-1:0] ic1,
    output logic [N-1:0] ic2,
    output logic [N-1:0] vK_M,
    output logic [N-1:0] vD_M,
    output logic [N-1:0] dt,
    output logic         busy
);

    localparam int IDX_W = $clog2(REG_BYTES);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RX_ARGS  = 3'd1,
        LOAD     = 3'd2,
        RUN      = 3'd3,
        TX_ISSUE = 3'd4,
        TX_WAIT  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         regs_q [REG_BYTES];
    logic [7:0]         regs_d [REG_BYTES];
    logic               is_load_q, is_load_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [15:0]        to_q, to_d;
    logic [31:0]        reply_q, reply_d;
    logic [2:0]         left_q, left_d;
    logic               seen_q, seen_d;
    logic               wcnt_q, wcnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            regs_q    <= '{default: 8'h00};
            is_load_q <= 1'b0;
            idx_q     <= '0;
            cnt_q     <= 16'd0;
            to_q      <= 16'd0;
            reply_q   <= 32'd0;
            left_q    <= 3'd0;
            seen_q    <= 1'b0;
            wcnt_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            regs_q    <= regs_d;
            is_load_q <= is_load_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            to_q      <= to_d;
            reply_q   <= reply_d;
            left_q    <= left_d;
            seen_q    <= seen_d;
            wcnt_q    <= wcnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        regs_d    = regs_q;
        is_load_d = is_load_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        to_d      = to_q;
        reply_d   = reply_q;
        left_d    = left_q;
        seen_d    = seen_q;
        wcnt_d    = wcnt_q;
        dda_load  = 1'b0;
        dda_en    = 1'b0;
        tx_start  = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    idx_d = '0;
                    to_d  = 16'd0;
                    case (rx_byte)
                        8'h01: begin
                            is_load_d = 1'b1;
                            state_d   = RX_ARGS;
                        end
                        8'h02: begin
                            is_load_d = 1'b0;
                            cnt_d     = 16'd0;
                            state_d   = RX_ARGS;
                        end
                        default: begin
                            reply_d = {8'hEE, 24'h000000};
                            left_d  = 3'd1;
                            state_d = TX_ISSUE;
                        end
                    endcase
                end
            end
            RX_ARGS: begin
                // The abort takes priority over a byte landing in the same cycle.
                if (to_q == 16'(TIMEOUT)) begin
                    state_d = IDLE;
                end else if (rx_valid) begin
                    to_d  = 16'd0;
                    idx_d = idx_q + 1'b1;
                    if (is_load_q) begin
                        regs_d[idx_q] = rx_byte;
                        if (idx_q == IDX_W'(REG_BYTES - 1)) begin
                            state_d = LOAD;
                        end
                    end else if (idx_q == '0) begin
                        cnt_d = {rx_byte, cnt_q[7:0]};
                    end else begin
                        cnt_d = {cnt_q[15:8], rx_byte};
                        if ({cnt_q[15:8], rx_byte} == 16'd0) begin
                            reply_d = {v1, v2};
                            left_d  = 3'd4;
                            state_d = TX_ISSUE;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end else begin
                    to_d = to_q + 16'd1;
                end
            end
            LOAD: begin
                dda_load = 1'b1;
                reply_d  = {8'h01, 24'h000000};
                left_d   = 3'd1;
                state_d  = TX_ISSUE;
            end
            RUN: begin
                if (cnt_q != 16'd0) begin
                    dda_en = 1'b1;
                    cnt_d  = cnt_q - 16'd1;
                end else begin
                    reply_d = {v1, v2};
                    left_d  = 3'd4;
                    state_d = TX_ISSUE;
                end
            end
            TX_ISSUE: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    seen_d   = 1'b0;
                    wcnt_d   = 1'b0;
                    state_d  = TX_WAIT;
                end
            end
            TX_WAIT: begin
                // A UART that never raises busy within two cycles is taken as done.
                if ((seen_q && !tx_busy) || (!seen_q && !tx_busy && wcnt_q)) begin
                    reply_d = {reply_q[23:0], 8'h00};
                    left_d  = left_q - 3'd1;
                    state_d = (left_q == 3'd1) ? IDLE : TX_ISSUE;
                end else if (!seen_q) begin
                    if (tx_busy) begin
                        seen_d = 1'b1;
                    end else begin
                        wcnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign tx_byte = reply_q[31:24];
    assign busy    = (state_q != IDLE);
    assign ic1     = {regs_q[0], regs_q[1]};
    assign ic2     = {regs_q[2], regs_q[3]};
    assign vK_M    = {regs_q[4], regs_q[5]};
    assign vD_M    = {regs_q[6], regs_q[7]};
    assign dt      = {regs_q[8], regs_q[9]};

endmodule
`default_nettype wire
